// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Frame-level controller for the mic-array pipeline (sampler, xcorr, argmax and
// the ping-pong sample banks). Once every stage reports standby, it swaps the
// banks and restarts all stages. When a frame finishes, it logs the argmax
// result, tagged with channel pair and frame number, into a small result FIFO.
// A stall watchdog aborts and retries a frame that never finishes.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   enable         run frames back to back while high
//   stage_standby  per-stage idle/done flags
//   max_idx        argmax index, valid while every stage is in standby
//   max_val        argmax value, valid while every stage is in standby
//   swap           one-cycle ping-pong bank switch pulse
//   stage_kick     one-cycle stage restart pulse
//   pair_sel       channel pair being processed, stable for a whole frame
//   busy           high in every state except IDLE
//   res_valid      result FIFO non-empty
//   res_ready      consumer pop strobe (pop = res_valid & res_ready)
//   res_pair       head entry channel pair
//   res_frame      head entry frame number
//   res_idx        head entry argmax index
//   res_val        head entry argmax value
//   frame_cnt      completed frames, wraps
//   timeout_err    sticky: the watchdog fired
//   overflow       sticky: a result was dropped because the FIFO was full
//   clr_err        clears both sticky flags
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int NUM_PAIRS   = 3,
    parameter int LAG_W       = 8,
    parameter int DATA_W      = 32,
    parameter int FRAME_W     = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_MASK  = 2,
    parameter int TIMEOUT_CYC = 4096,
    localparam int PAIR_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_STAGES-1:0] stage_standby,
    input  logic [LAG_W-1:0]      max_idx,
    input  logic [DATA_W-1:0]     max_val,
    output logic                  swap,
    output logic                  stage_kick,
    output logic [PAIR_W-1:0]     pair_sel,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [PAIR_W-1:0]     res_pair,
    output logic [FRAME_W-1:0]    res_frame,
    output logic [LAG_W-1:0]      res_idx,
    output logic [DATA_W-1:0]     res_val,
    output logic [FRAME_W-1:0]    frame_cnt,
    output logic                  timeout_err,
    output logic                  overflow,
    input  logic                  clr_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int ENTRY_W = PAIR_W + FRAME_W + LAG_W + DATA_W;

    localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]   WD_MASK    = WD_W'(START_MASK);
    localparam logic [PAIR_W-1:0] PAIR_LAST  = PAIR_W'(NUM_PAIRS - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP,
        S_KICK,
        S_RUN,
        S_CAPTURE,
        S_ABORT
    } state_t;

    state_t state;
    state_t next_state;

    logic              all_sb;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_en;
    logic              push_drop;
    logic [WD_W-1:0]   wd_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    assign all_sb    = &stage_standby;
    assign busy      = (state != S_IDLE);
    assign res_valid = (count != '0);
    assign full      = (count == FIFO_FULL);
    assign pop       = res_valid & res_ready;
    // A full FIFO still accepts a push when the consumer pops in the same cycle.
    assign push_en   = push & (~full | pop);
    assign push_drop = push & full & ~pop;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pulse decode. While the watchdog count is still below
    // START_MASK the stages may not have dropped standby yet after the kick,
    // so all_sb is not trusted. A genuine completion outranks the timeout
    // when both land in the final watchdog cycle.
    always_comb begin
        next_state = state;
        swap       = 1'b0;
        stage_kick = 1'b0;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && all_sb) begin
                    next_state = S_SWAP;
                end
            end
            S_SWAP: begin
                swap       = 1'b1;
                next_state = S_KICK;
            end
            S_KICK: begin
                stage_kick = 1'b1;
                next_state = S_RUN;
            end
            S_RUN: begin
                if ((wd_cnt >= WD_MASK) && all_sb) begin
                    next_state = S_CAPTURE;
                end else if (wd_cnt == WD_LAST) begin
                    next_state = S_ABORT;
                end
            end
            S_CAPTURE: begin
                push       = 1'b1;
                next_state = enable ? S_SWAP : S_IDLE;
            end
            S_ABORT: begin
                stage_kick = 1'b1;
                next_state = enable ? S_KICK : S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Watchdog: holds the number of cycles already spent in RUN. It is
    // cleared by every kick, so an aborted frame gets a fresh budget on retry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == S_KICK) begin
            wd_cnt <= '0;
        end else if (state == S_RUN) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Frame number and channel-pair round robin advance only on a completed
    // frame. An aborted frame retries the same pair and frame number.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            pair_sel  <= '0;
        end else if (state == S_CAPTURE) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
            if (pair_sel == PAIR_LAST) begin
                pair_sel <= '0;
            end else begin
                pair_sel <= pair_sel + PAIR_W'(1);
            end
        end
    end

    // Sticky error flags. A new error event in the same cycle as clr_err
    // keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (state == S_ABORT) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    // Result FIFO storage. Entries are cleared on reset so the head outputs
    // read zero while the FIFO is empty after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_en) begin
            mem[wr_ptr] <= {pair_sel, frame_cnt, max_idx, max_val};
        end
    end

    // FIFO pointers and occupancy. The depth is a power of two, so the
    // pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head of the FIFO is presented directly from the storage registers
    // (first-word-fall-through).
    assign {res_pair, res_frame, res_idx, res_val} = mem[rd_ptr];

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Directed-sequence bench for frame_sequencer with randomized run lengths and
// argmax data. The stages are emulated inline. The expected results come from
// a transaction-level model: a queue of logged entries, a frame counter,
// a pair counter and the sticky flags.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int NUM_STAGES  = 3;
    localparam int NUM_PAIRS   = 3;
    localparam int LAG_W       = 8;
    localparam int DATA_W      = 32;
    localparam int FRAME_W     = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int START_MASK  = 2;
    localparam int TIMEOUT_CYC = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [NUM_STAGES-1:0] stage_standby;
    logic [LAG_W-1:0]      max_idx;
    logic [DATA_W-1:0]     max_val;
    logic                  swap;
    logic                  stage_kick;
    logic [1:0]            pair_sel;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [1:0]            res_pair;
    logic [FRAME_W-1:0]    res_frame;
    logic [LAG_W-1:0]      res_idx;
    logic [DATA_W-1:0]     res_val;
    logic [FRAME_W-1:0]    frame_cnt;
    logic                  timeout_err;
    logic                  overflow;
    logic                  clr_err;

    frame_sequencer #(
        .NUM_STAGES (NUM_STAGES),
        .NUM_PAIRS  (NUM_PAIRS),
        .LAG_W      (LAG_W),
        .DATA_W     (DATA_W),
        .FRAME_W    (FRAME_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .START_MASK (START_MASK),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .stage_standby(stage_standby),
        .max_idx      (max_idx),
        .max_val      (max_val),
        .swap         (swap),
        .stage_kick   (stage_kick),
        .pair_sel     (pair_sel),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_pair     (res_pair),
        .res_frame    (res_frame),
        .res_idx      (res_idx),
        .res_val      (res_val),
        .frame_cnt    (frame_cnt),
        .timeout_err  (timeout_err),
        .overflow     (overflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pair;
        int          frame;
        logic [7:0]  idx;
        logic [31:0] val;
    } entry_t;

    entry_t exp_q[$];
    int     checks    = 0;
    int     failures  = 0;
    int     exp_frame = 0;
    int     exp_pair  = 0;
    logic   exp_ovf   = 1'b0;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] sb,
                                 input logic ready, input logic clr);
        enable        = en;
        stage_standby = sb;
        res_ready     = ready;
        clr_err       = clr;
    endtask

    // Compare the FIFO head with the oldest entry the model expects.
    task automatic checkHead(input string tag);
        checkOutput({tag, "_res_valid"}, res_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            checkOutput({tag, "_res_pair"},  res_pair,  exp_q[0].pair);
            checkOutput({tag, "_res_frame"}, res_frame, exp_q[0].frame);
            checkOutput({tag, "_res_idx"},   res_idx,   exp_q[0].idx);
            checkOutput({tag, "_res_val"},   res_val,   exp_q[0].val);
        end
    endtask

    // Model of one completed frame: optional simultaneous pop, then a push
    // that is dropped (and flagged) if no room remains.
    task automatic modelCapture(input logic [7:0] idx, input logic [31:0] val,
                                input bit pop_now);
        entry_t e;
        if (pop_now && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        e.pair  = exp_pair;
        e.frame = exp_frame;
        e.idx   = idx;
        e.val   = val;
        if (exp_q.size() < FIFO_DEPTH) begin
            exp_q.push_back(e);
        end else begin
            exp_ovf = 1'b1;
        end
        exp_frame = (exp_frame + 1) % (1 << FRAME_W);
        exp_pair  = (exp_pair + 1) % NUM_PAIRS;
    endtask

    task automatic waitSwap(input string tag);
        int n = 0;
        while (swap !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput({tag, "_swap_seen"}, swap, 1'b1);
        checkOutput({tag, "_no_kick_with_swap"}, stage_kick, 1'b0);
    endtask

    // One frame: the stages drop standby after the kick for 'low' cycles and
    // then present the argmax result. 'stop' drops enable mid-frame. 'pop_cap'
    // pops the FIFO in the same cycle as the capture.
    task automatic doFrame(input int low, input logic [7:0] idx, input logic [31:0] val,
                           input bit stop, input bit pop_cap, input string tag);
        int extra;
        enable = 1'b1;
        waitSwap(tag);
        checkOutput({tag, "_pair_sel"}, pair_sel, exp_pair);
        tick();
        checkOutput({tag, "_kick"}, {swap, stage_kick}, 2'b01);
        tick();
        if (low > 0) begin
            stage_standby = 3'($urandom_range(0, 6));
        end
        max_idx = 8'($urandom);
        max_val = $urandom;
        if (stop) begin
            enable = 1'b0;
        end
        repeat (low) tick();
        stage_standby = 3'b111;
        max_idx       = idx;
        max_val       = val;
        extra = (low < START_MASK) ? (START_MASK - low) : 0;
        for (int i = 0; i < extra; i++) begin
            tick();
            checkOutput({tag, "_masked_no_capture"}, frame_cnt, exp_frame);
        end
        tick();
        checkOutput({tag, "_capture_pulses"}, {busy, swap, stage_kick}, 3'b100);
        if (pop_cap) begin
            checkHead({tag, "_prepop"});
            res_ready = 1'b1;
        end
        tick();
        res_ready = 1'b0;
        modelCapture(idx, val, pop_cap);
        checkOutput({tag, "_frame_cnt"}, frame_cnt, exp_frame);
        checkOutput({tag, "_overflow"},  overflow,  exp_ovf);
        checkOutput({tag, "_busy_after"}, busy, !stop);
        checkHead(tag);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (n < 2 * FIFO_DEPTH + 2) begin
            checkHead(tag);
            if (exp_q.size() == 0) break;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            void'(exp_q.pop_front());
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int swaps_seen;
        int kicks_seen;
        logic [7:0]  w_idx;
        logic [31:0] w_val;

        applyStimulus(1'b0, 3'b111, 1'b0, 1'b0);
        max_idx = '0;
        max_val = '0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset and idle: every output stays low while enable is low.
        for (int i = 0; i < 20; i++) begin
            checkOutput("t1_outputs", {swap, stage_kick, pair_sel, busy, res_valid, res_pair,
                        res_frame, res_idx, frame_cnt, timeout_err, overflow}, 64'd0);
            checkOutput("t1_res_val", res_val, 64'd0);
            tick();
        end

        // Nominal frame with fixed data, stopped so the block parks in IDLE.
        doFrame(50, 8'h2A, 32'h100, 1'b1, 1'b0, "t2");
        checkOutput("t2_entry", {res_pair, res_frame, res_idx, res_val}, {2'd0, 16'd0, 8'h2A, 32'h100});
        drain("t2_drain");

        // Six frames without popping: the FIFO fills, later results drop.
        for (int f = 0; f < 6; f++) begin
            doFrame($urandom_range(0, 20), 8'($urandom), $urandom, f == 5, 1'b0, "t5_fill");
        end
        checkOutput("t5_overflow_set", overflow, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_ovf = 1'b0;
        checkOutput("t5_overflow_clr", overflow, 1'b0);
        drain("t5_drain");

        // Fill to full, then capture while popping in the same cycle.
        for (int f = 0; f < 4; f++) begin
            doFrame($urandom_range(2, 12), 8'($urandom), $urandom, f == 3, 1'b0, "t3_fill");
        end
        doFrame($urandom_range(2, 12), 8'($urandom), $urandom, 1'b1, 1'b1, "t5_pushpop");
        checkOutput("t5_pushpop_no_ovf", overflow, 1'b0);
        drain("t3_drain");

        // Watchdog: one stage stays low for 100 cycles after the kick.
        enable = 1'b1;
        waitSwap("t4");
        tick();
        checkOutput("t4_kick", stage_kick, 1'b1);
        tick();
        stage_standby = 3'b110;
        swaps_seen = 0;
        kicks_seen = 0;
        for (int t = 1; t < TIMEOUT_CYC; t++) begin
            tick();
            swaps_seen += int'(swap);
            kicks_seen += int'(stage_kick);
        end
        tick();
        checkOutput("t4_abort_kick", {swap, stage_kick, busy}, 3'b011);
        checkOutput("t4_abort_state", {frame_cnt, pair_sel}, {exp_frame[15:0], exp_pair[1:0]});
        tick();
        checkOutput("t4_rekick", {swap, stage_kick}, 2'b01);
        checkOutput("t4_timeout_err", timeout_err, 1'b1);
        enable = 1'b0;
        for (int t = TIMEOUT_CYC + 2; t <= 100; t++) begin
            tick();
            swaps_seen += int'(swap);
            kicks_seen += int'(stage_kick);
        end
        w_idx = 8'($urandom);
        w_val = $urandom;
        stage_standby = 3'b111;
        max_idx = w_idx;
        max_val = w_val;
        tick();
        tick();
        modelCapture(w_idx, w_val, 1'b0);
        checkOutput("t4_no_swap", swaps_seen, 0);
        checkOutput("t4_no_stray_kick", kicks_seen, 0);
        checkOutput("t4_frame_cnt", frame_cnt, exp_frame);
        checkOutput("t4_idle", busy, 1'b0);
        checkHead("t4_entry");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("t4_flags_clr", {timeout_err, overflow}, 2'b00);
        drain("t4_drain");

        // Reset in the middle of RUN with a result already queued.
        doFrame($urandom_range(2, 8), 8'($urandom), $urandom, 1'b1, 1'b0, "t6_pre");
        enable = 1'b1;
        waitSwap("t6");
        tick();
        tick();
        stage_standby = 3'b000;
        repeat (5) tick();
        rst = 1'b1;
        enable = 1'b0;
        stage_standby = 3'b111;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_frame = 0;
        exp_pair  = 0;
        exp_ovf   = 1'b0;
        checkOutput("t6_after_rst", {busy, res_valid, frame_cnt, pair_sel, timeout_err, overflow}, 64'd0);
        doFrame($urandom_range(0, 10), 8'($urandom), $urandom, 1'b1, 1'b0, "t6_post");
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
